// File: rtl/pixel_frame_writer.sv
// Pixel frame writer: decodes aligned SYNC/DATA/NULL_RUN words
// and writes pixels into a multi-slot frame buffer.
module pixel_frame_writer #(
  parameter logic [20:0] SYNC_WORD        = 21'h1FFFFF,
  parameter int          PIXELS_PER_FRAME = 1024,
  parameter int          NUM_FRAMES       = 16
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        valid_in,
  input  logic [20:0] data_in,
  output logic        ready_out,
  output logic [10:0] fb_din,
  output logic [13:0] fb_addr,
  output logic        fb_we,
  output logic [3:0]  frame_idx,
  output logic        frame_done,
  output logic        err_sync,
  output logic        err_overrun
);

  typedef enum logic [1:0] {
    WAIT_SYNC,
    RECV,
    ZERO_FILL
  } state_t;

  localparam logic [10:0] LAST_PIX = 11'(PIXELS_PER_FRAME - 1);
  localparam logic [3:0]  LAST_IDX = 4'(NUM_FRAMES - 1);

  state_t      state_q, state_d;
  logic [10:0] cnt_q, cnt_d;
  logic [10:0] rem_q, rem_d;
  logic [3:0]  idx_d;
  logic [10:0] din_d;
  logic [13:0] addr_d;
  logic        we_d, done_d, esync_d, eovr_d;

  logic        accept, is_sync, is_data;
  logic [10:0] run_len;
  logic        wr;
  logic [10:0] wval;

  assign ready_out = (state_q != ZERO_FILL);
  assign accept    = valid_in & ready_out;
  assign is_sync   = (data_in == SYNC_WORD);
  assign is_data   = ~is_sync & ~data_in[20];
  assign run_len   = data_in[10:0];

  // Next-state, counters and registered-output values
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    rem_d   = rem_q;
    idx_d   = frame_idx;
    din_d   = fb_din;
    addr_d  = fb_addr;
    we_d    = 1'b0;
    done_d  = 1'b0;
    esync_d = 1'b0;
    eovr_d  = 1'b0;
    wr      = 1'b0;
    wval    = '0;
    unique case (state_q)
      WAIT_SYNC: begin
        if (accept && is_sync) begin
          cnt_d   = '0;
          state_d = RECV;
        end
      end
      RECV: begin
        if (accept) begin
          if (is_sync) begin
            esync_d = 1'b1;
            cnt_d   = '0;
          end else if (is_data) begin
            wr   = 1'b1;
            wval = data_in[10:0];
          end else if (run_len != '0) begin
            wr    = 1'b1;
            rem_d = run_len - 11'd1;
            if (run_len != 11'd1)
              state_d = ZERO_FILL;
          end
        end
      end
      ZERO_FILL: begin
        wr    = 1'b1;
        rem_d = rem_q - 11'd1;
        if (rem_q == 11'd1)
          state_d = RECV;
      end
      default: state_d = WAIT_SYNC;
    endcase
    if (wr) begin
      we_d   = 1'b1;
      din_d  = wval;
      addr_d = {frame_idx, cnt_q[9:0]};
      cnt_d  = cnt_q + 11'd1;
      if (cnt_q == LAST_PIX) begin
        done_d  = 1'b1;
        eovr_d  = (rem_d != '0);
        rem_d   = '0;
        cnt_d   = '0;
        idx_d   = (frame_idx == LAST_IDX) ? 4'd0 : frame_idx + 4'd1;
        state_d = WAIT_SYNC;
      end
    end
  end

  // State, counters and output registers
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= WAIT_SYNC;
      cnt_q       <= '0;
      rem_q       <= '0;
      frame_idx   <= '0;
      fb_din      <= '0;
      fb_addr     <= '0;
      fb_we       <= 1'b0;
      frame_done  <= 1'b0;
      err_sync    <= 1'b0;
      err_overrun <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      rem_q       <= rem_d;
      frame_idx   <= idx_d;
      fb_din      <= din_d;
      fb_addr     <= addr_d;
      fb_we       <= we_d;
      frame_done  <= done_d;
      err_sync    <= esync_d;
      err_overrun <= eovr_d;
    end
  end

endmodule

// File: doc/pixel_frame_writer.md
PIXEL_FRAME_WRITER -- requirements
Module: pixel_frame_writer

Interface
REQ-001 The block SHALL have parameter SYNC_WORD, default 21'h1FFFFF, meaning the frame-start marker word.
REQ-002 The block SHALL have parameter PIXELS_PER_FRAME, default 1024, meaning the number of pixels per frame.
REQ-003 The block SHALL have parameter NUM_FRAMES, default 16, meaning the number of frame slots in the buffer.
REQ-004 The block SHALL have port clk, input, 1 bit: the single clock; all logic is on its rising edge.
REQ-005 The block SHALL have port rst, input, 1 bit: synchronous, active-high reset.
REQ-006 The block SHALL have port valid_in, input, 1 bit: data_in is valid (driven by the upstream align stage).
REQ-007 The block SHALL have port data_in, input, 21 bits: one aligned 21-bit word.
REQ-008 The block SHALL have port ready_out, output, 1 bit: word accepted when valid_in and ready_out are both high.
REQ-009 The block SHALL have port fb_din, output, 11 bits: pixel value to the frame buffer.
REQ-010 The block SHALL have port fb_addr, output, 14 bits: frame buffer address {frame_idx, pixel_cnt}.
REQ-011 The block SHALL have port fb_we, output, 1 bit: frame buffer write strobe.
REQ-012 The block SHALL have port frame_idx, output, 4 bits: slot of the frame currently being filled.
REQ-013 The block SHALL have port frame_done, output, 1 bit: one-cycle pulse when a frame completes.
REQ-014 The block SHALL have port err_sync, output, 1 bit: one-cycle pulse when SYNC arrives mid-frame.
REQ-015 The block SHALL have port err_overrun, output, 1 bit: one-cycle pulse when a null run is truncated at the frame end.

Function
REQ-016 Word decode SHALL be: data_in == SYNC_WORD gives SYNC; else bit20=0 gives DATA (pixel = [10:0]); else bit20=1 gives NULL_RUN (length N = [10:0]).
REQ-017 The FSM SHALL have states WAIT_SYNC, RECV and ZERO_FILL.
REQ-018 ready_out SHALL be combinational and equal (state != ZERO_FILL).
REQ-019 fb_we, fb_din, fb_addr, frame_done, err_sync and err_overrun SHALL be registered, with 1-cycle latency from acceptance.
REQ-020 In WAIT_SYNC, accepted DATA and NULL_RUN words SHALL be discarded with no write.
REQ-021 In WAIT_SYNC, an accepted SYNC SHALL set pixel_cnt=0 and move to RECV.
REQ-022 In RECV, an accepted DATA word SHALL produce fb_we=1, fb_din=pixel, fb_addr={frame_idx,pixel_cnt}, and increment pixel_cnt.
REQ-023 In RECV, an accepted NULL_RUN with N=0 SHALL be a no-op.
REQ-024 In RECV, an accepted NULL_RUN with N>=1 SHALL write zero at pixel_cnt, then go to ZERO_FILL for the remaining N-1 zero writes, one per cycle, with ready_out=0.
REQ-025 In ZERO_FILL, the block SHALL return to RECV after the last zero write.
REQ-026 A NULL_RUN that exceeds the pixels remaining in the frame SHALL stop after address offset 1023, pulse err_overrun with the last write, and discard the residual run.
REQ-027 In RECV, an accepted SYNC SHALL pulse err_sync, reset pixel_cnt to 0 and keep frame_idx (the partial frame is overwritten).
REQ-028 The write to offset PIXELS_PER_FRAME-1 SHALL coincide with a frame_done pulse, increment frame_idx modulo NUM_FRAMES (15 wraps to 0) and move the FSM to WAIT_SYNC.
REQ-029 frame_idx SHALL change in the cycle after the frame_done write, so the final fb_addr uses the old index.
REQ-030 pixel_cnt SHALL be 11 bits wide internally, and only [9:0] SHALL appear on fb_addr.
REQ-031 Outputs SHALL never write when valid_in is low, except during ZERO_FILL.

Reset
REQ-032 rst high at a clock edge SHALL force state=WAIT_SYNC, pixel_cnt=0, frame_idx=0, fb_we=0, fb_din=0, fb_addr=0, frame_done=0, err_sync=0 and err_overrun=0.
REQ-033 ready_out SHALL be 1 after reset.
REQ-034 Reset SHALL take priority over all events, including mid-ZERO_FILL; any pending zero run SHALL be abandoned.

Verification
REQ-035 Reset, SYNC, then 1024 DATA words with pixel=i -> writes at addr 0..1023 with din=i; frame_done with addr 1023; frame_idx becomes 1; FSM returns to WAIT_SYNC.
REQ-036 SYNC, DATA 5, NULL_RUN 3, DATA 7 -> writes addr0=5, addr1..3=0, addr4=7; ready_out low for exactly 2 cycles.
REQ-037 SYNC, 1000 DATA, NULL_RUN 100 -> 24 zero writes at addr 1000..1023; err_overrun and frame_done coincide with the addr-1023 write; no further writes until the next SYNC.
REQ-038 16 complete frames -> frame_idx steps 0..15 then wraps to 0; the 17th frame writes at addr 0x0000-0x03FF.
REQ-039 SYNC, 10 DATA, SYNC, DATA 9 -> err_sync pulses once; DATA 9 is written at {frame_idx,0}; frame_idx is unchanged.
REQ-040 Reset asserted during ZERO_FILL of NULL_RUN 50 -> fb_we=0 and ready_out=1 the next cycle with frame_idx=0; DATA words before a new SYNC produce no writes.
